psum_drain_ctrl: RTL
====================

Name: psum_drain_ctrl

Overview:
- Sits directly upstream of the SFU controller.
- Drains per-kij partial-sum vectors from the output FIFO of the systolic array into PSUM memory, using the layout addr = kij*num_nij + nij.
- After all num_kij*num_nij vectors are stored, pulses start_sfu and waits for the SFU pass to finish before reporting done.
- Top level uses kij_done to reload weights for the next kij.

Parameters:
- ADDR_W, 11, PSUM memory address width.
- num_nij, 36, input pixels per kij pass (vectors per kij).
- num_kij, 9, kernel positions per layer.
- num_oc, 8, output channels per vector.
- PSUM_BW, 16, bits per channel partial sum.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begin draining a layer.
- ofifo_valid  in  1  OFIFO holds at least one vector.
- ofifo_out  in  num_oc*PSUM_BW  OFIFO read data, valid the cycle after ofifo_rd.
- ofifo_rd  out  1  OFIFO pop request.
- psum_mem_addr  out  ADDR_W  PSUM memory write address.
- psum_mem_wr_enable  out  1  PSUM memory write strobe.
- psum_mem_din  out  num_oc*PSUM_BW  PSUM memory write data.
- kij_done  out  1  one-cycle pulse after the last write of each kij.
- kij_idx  out  4  kij currently being drained.
- start_sfu  out  1  one-cycle pulse to the SFU controller.
- sfu_active  in  1  SFU controller busy flag.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at layer completion.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE; all counters go to 0.
  - All outputs go to 0, including psum_mem_din and psum_mem_addr.
  - Reset mid-operation abandons the layer with no further rd or wr activity.
  - OFIFO contents are the top level's responsibility.
- States: IDLE, DRAIN, FLUSH, HANDOFF, WAIT_SFU.
- IDLE:
  - start -> DRAIN, busy<=1, counters cleared.
  - start is ignored in every other state.
- DRAIN:
  - ofifo_rd is combinational: ofifo_rd = ofifo_valid and (rd_cnt < num_kij*num_nij).
  - Gaps in ofifo_valid stall the drain with no reads.
  - Each read increments rd_cnt.
  - rd_cnt reaching num_kij*num_nij -> FLUSH.
- Write pipeline (one-cycle latency):
  - A read at cycle t produces psum_mem_wr_enable=1 at cycle t+1.
  - psum_mem_din = ofifo_out at t+1 (pass-through of the t+1 value, registered enable/address).
  - Address at t+1 = kij_cnt*num_nij + nij_cnt, with ADDR_W-bit arithmetic. Max address num_kij*num_nij-1 must fit ADDR_W; this is checked by a simulation assertion.
  - After each write: nij_cnt increments. At nij_cnt==num_nij-1 it wraps to 0, kij_cnt increments and kij_done pulses in the same cycle as that write.
  - kij_idx = kij_cnt.
- FLUSH: waits one cycle for the final write, then -> HANDOFF.
- HANDOFF: start_sfu=1 for exactly one cycle -> WAIT_SFU.
- WAIT_SFU:
  - Waits for sfu_active to be seen high, then low.
  - This is tracked with a seen_active flag, because the controller raises sfu_active one cycle after start_sfu.
  - On low after high: done pulses, busy<=0 -> IDLE.
- psum_mem_wr_enable is never high outside the cycle after a read.
- Total writes per layer are exactly num_kij*num_nij.
- Simultaneous start and reset: reset wins.

Decomposition:
- Shared package holds the state encoding constants and the address helper: kij*num_nij+nij.
- One natural sub-module: psum_addr_gen, which owns the nij/kij counters, the address register and the kij_done pulse.
- The FSM and the rd/wr pipeline stay in psum_drain_ctrl.

Test Plan:
- Continuous valid: hold ofifo_valid=1 after start.
  - Expect 324 reads in 324 consecutive cycles and writes at addresses 0..323 in order, each one cycle after its read.
  - Expect kij_done at writes to 35, 71, …, 323, then start_sfu 2 cycles after the last write.
- Bubbly valid: toggle ofifo_valid 1/0.
  - Expect no rd while valid==0 and write count still 324.
  - Expect address 36 to carry the 37th popped vector, with psum_mem_din matching the FIFO model.
- SFU handshake: sfu_active rises 1 cycle after start_sfu and falls 200 cycles later.
  - Expect done exactly 1 cycle after the fall and busy low from then.
  - Expect done never before sfu_active has been seen high.
- Start while busy: pulse start at write 100.
  - Expect no counter reset and addresses continuing 100, 101, ….
- Reset mid-DRAIN: drive reset=0 for 1 cycle at write 50.
  - Expect all outputs 0 next cycle and no rd/wr until a new start.
  - After the new start, the first write goes to address 0.

Source files
------------

// File: rtl/psum_drain_ctrl_pkg.sv
// Shared state encoding and PSUM address helper for the partial-sum drain controller.
package psum_drain_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH,
        S_HANDOFF,
        S_WAIT_SFU
    } drain_state_t;

    // PSUM layout: one row of num_nij vectors per kernel position.
    function automatic int unsigned psum_addr(
        input int unsigned kij,
        input int unsigned nij,
        input int unsigned n_nij
    );
        return kij * n_nij + nij;
    endfunction

endpackage

// File: rtl/psum_addr_gen.sv
// Tracks the nij/kij position of the drain and produces the registered PSUM write
// address plus the per-kij completion pulse, aligned with the write strobe.
module psum_addr_gen
    import psum_drain_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned num_nij = 36,
    parameter int unsigned num_kij = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_kij_done,
    output logic [3:0]        o_kij_idx
);

    localparam int unsigned NW = (num_nij > 1) ? $clog2(num_nij) : 1;
    localparam int unsigned KW = $clog2(num_kij + 1);

    logic [NW-1:0]     r_nij;
    logic [KW-1:0]     r_kij;
    logic [ADDR_W-1:0] r_addr;
    logic              r_kij_done;
    logic              w_nij_last;

    assign w_nij_last = (r_nij == NW'(num_nij - 1));

    // Counters advance on the read so address and kij_done land with the write a cycle later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_nij      <= '0;
            r_kij      <= '0;
            r_addr     <= '0;
            r_kij_done <= 1'b0;
        end else begin
            r_kij_done <= 1'b0;
            if (i_clear) begin
                r_nij  <= '0;
                r_kij  <= '0;
                r_addr <= '0;
            end else if (i_advance) begin
                r_addr     <= ADDR_W'(psum_addr(32'(r_kij), 32'(r_nij), num_nij));
                r_kij_done <= w_nij_last;
                if (w_nij_last) begin
                    r_nij <= '0;
                    r_kij <= r_kij + 1'b1;
                end else begin
                    r_nij <= r_nij + 1'b1;
                end
            end
        end
    end

    assign o_addr     = r_addr;
    assign o_kij_done = r_kij_done;
    assign o_kij_idx  = 4'(r_kij);

endmodule

// File: rtl/psum_drain_ctrl.sv
// Drains OFIFO partial-sum vectors into PSUM memory for a whole layer, then hands
// off to the SFU controller and waits for its pass to finish.
module psum_drain_ctrl
    import psum_drain_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned num_nij = 36,
    parameter int unsigned num_kij = 9,
    parameter int unsigned num_oc  = 8,
    parameter int unsigned PSUM_BW = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      ofifo_valid,
    input  logic [num_oc*PSUM_BW-1:0] ofifo_out,
    output logic                      ofifo_rd,
    output logic [ADDR_W-1:0]         psum_mem_addr,
    output logic                      psum_mem_wr_enable,
    output logic [num_oc*PSUM_BW-1:0] psum_mem_din,
    output logic                      kij_done,
    output logic [3:0]                kij_idx,
    output logic                      start_sfu,
    input  logic                      sfu_active,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned TOTAL = num_kij * num_nij;
    localparam int unsigned RCW   = $clog2(TOTAL + 1);
    localparam logic [RCW-1:0] TOTAL_C = RCW'(TOTAL);
    localparam logic [RCW-1:0] LAST_RD = RCW'(TOTAL - 1);

    drain_state_t   r_state;
    logic [RCW-1:0] r_rd_cnt;
    logic           r_wr_en;
    logic           r_start_sfu;
    logic           r_busy;
    logic           r_done;
    logic           r_seen_active;
    logic           w_rd;
    logic           w_clear;

    assign w_rd    = (r_state == S_DRAIN) && ofifo_valid && (r_rd_cnt < TOTAL_C);
    assign w_clear = (r_state == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_rd_cnt      <= '0;
            r_wr_en       <= 1'b0;
            r_start_sfu   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_seen_active <= 1'b0;
        end else begin
            r_wr_en     <= w_rd;
            r_start_sfu <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_DRAIN;
                        r_busy        <= 1'b1;
                        r_rd_cnt      <= '0;
                        r_seen_active <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_rd) begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                        if (r_rd_cnt == LAST_RD) r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: r_state <= S_HANDOFF;
                S_HANDOFF: begin
                    r_start_sfu <= 1'b1;
                    r_state     <= S_WAIT_SFU;
                end
                // sfu_active lags start_sfu, so completion needs a high level seen first.
                S_WAIT_SFU: begin
                    if (sfu_active) begin
                        r_seen_active <= 1'b1;
                    end else if (r_seen_active) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    psum_addr_gen #(
        .ADDR_W (ADDR_W),
        .num_nij(num_nij),
        .num_kij(num_kij)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_advance (w_rd),
        .o_addr    (psum_mem_addr),
        .o_kij_done(kij_done),
        .o_kij_idx (kij_idx)
    );

    assign ofifo_rd           = w_rd;
    assign psum_mem_wr_enable = r_wr_en;
    assign psum_mem_din       = r_wr_en ? ofifo_out : '0;
    assign start_sfu          = r_start_sfu;
    assign busy               = r_busy;
    assign done               = r_done;

    a_addr_fits: assert property (@(posedge clk)
        longint'(TOTAL) <= (longint'(1) << ADDR_W));

endmodule
